// File: rtl/hqc_decod_pkg.sv
// Shared state encoding and security-level lookups for the HQC
// concatenated-decode sequencer.
package hqc_decod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RM_START,
    ST_RM_WAIT,
    ST_RS_START,
    ST_RS_WAIT,
    ST_FIN
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int TO_W_DEF        = 13;

  // n1: number of RS symbols (bytes) the RM decoder hands over.
  function automatic int n1_f(input int sec);
    case (sec)
      192:     return 56;
      256:     return 90;
      default: return 46;
    endcase
  endfunction

  function automatic int mid_aw_f(input int sec);
    return (sec == 256) ? 7 : 6;
  endfunction

endpackage

// File: rtl/hqc_decod_seq_if.sv
// Control, RM-write, RS-read and intermediate-RAM signals of the sequencer.
// master = sequencer side, slave = decap / decoders / RAM side.
interface hqc_decod_seq_if #(
  parameter int MID_AW = 6
);
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              rm_start_o;
  logic              rm_done_i;
  logic              rm_wr_i;
  logic [MID_AW-1:0] rm_addr_i;
  logic [7:0]        rm_dout_i;
  logic              rs_start_o;
  logic              rs_done_i;
  logic              rs_rd_i;
  logic [MID_AW-1:0] rs_addr_i;
  logic              mid_en_o;
  logic              mid_we_o;
  logic [MID_AW-1:0] mid_addr_o;
  logic [7:0]        mid_din_o;

  modport master (
    input  start_i, rm_done_i, rm_wr_i, rm_addr_i, rm_dout_i,
           rs_done_i, rs_rd_i, rs_addr_i,
    output busy_o, done_o, err_o, rm_start_o, rs_start_o,
           mid_en_o, mid_we_o, mid_addr_o, mid_din_o
  );

  modport slave (
    output start_i, rm_done_i, rm_wr_i, rm_addr_i, rm_dout_i,
           rs_done_i, rs_rd_i, rs_addr_i,
    input  busy_o, done_o, err_o, rm_start_o, rs_start_o,
           mid_en_o, mid_we_o, mid_addr_o, mid_din_o
  );
endinterface

// File: rtl/hqc_decod_wdog.sv
// Per-phase watchdog: counts cycles while run_i is high, restarts from zero
// whenever run_i drops, and flags the last permitted cycle.
module hqc_decod_wdog #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic timeout_o
);
  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_d, cnt_q;

  always_comb cnt_d = run_i ? cnt_q + 1'b1 : '0;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_o = run_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/hqc_decod_seq.sv
// Sequences RM then RS decoding, owns the intermediate byte RAM port mux,
// and reports done/err with watchdog and RM write-count checking.
module hqc_decod_seq
  import hqc_decod_pkg::*;
#(
  parameter int PARAM_SECURITY = 128,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
  parameter int TO_W           = TO_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  hqc_decod_seq_if.master io
);
  localparam int                N1       = n1_f(PARAM_SECURITY);
  localparam int                MID_AW   = mid_aw_f(PARAM_SECURITY);
  localparam logic [MID_AW-1:0] WCNT_EXP = MID_AW'(N1);

  state_e            state_d, state_q;
  logic              err_d, err_q;
  logic [MID_AW-1:0] wcnt_d, wcnt_q;
  logic              in_wait;
  logic              timeout;

  assign in_wait = (state_q == ST_RM_WAIT) || (state_q == ST_RS_WAIT);

  hqc_decod_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .run_i     (in_wait),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE:     if (io.start_i) state_d = ST_RM_START;
      ST_RM_START: begin
        wcnt_d  = '0;
        err_d   = 1'b0;
        state_d = ST_RM_WAIT;
      end
      ST_RM_WAIT: begin
        if (io.rm_wr_i && (wcnt_q != '1)) wcnt_d = wcnt_q + 1'b1;
        // A done pulse takes priority over a same-cycle timeout.
        if (io.rm_done_i) begin
          if (wcnt_q == WCNT_EXP) begin
            state_d = ST_RS_START;
          end else begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end
      end
      ST_RS_START: state_d = ST_RS_WAIT;
      ST_RS_WAIT: begin
        if (io.rs_done_i) begin
          state_d = ST_FIN;
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end
      end
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign io.busy_o     = (state_q != ST_IDLE);
  assign io.rm_start_o = (state_q == ST_RM_START);
  assign io.rs_start_o = (state_q == ST_RS_START);
  assign io.done_o     = (state_q == ST_FIN);
  assign io.err_o      = (state_q == ST_FIN) && err_q;

  // RAM ownership follows the phase; the non-owner's strobes never reach the RAM.
  always_comb begin
    io.mid_en_o   = 1'b0;
    io.mid_we_o   = 1'b0;
    io.mid_addr_o = '0;
    io.mid_din_o  = '0;
    unique case (state_q)
      ST_RM_START, ST_RM_WAIT: begin
        io.mid_en_o   = io.rm_wr_i;
        io.mid_we_o   = io.rm_wr_i;
        io.mid_addr_o = io.rm_addr_i;
        io.mid_din_o  = io.rm_dout_i;
      end
      ST_RS_START, ST_RS_WAIT: begin
        io.mid_en_o   = io.rs_rd_i;
        io.mid_addr_o = io.rs_addr_i;
      end
      default: ;
    endcase
  end

endmodule
